// File: rtl/regfile_decode_wb.sv
// Y86-64 style decode / write-back stage: source/destination decode, 15x64 register file, retire counter.
// Define REGFILE_DECODE_WB_BYPASS_EN to forward write-back data onto valA/valB in the same cycle.
module regfile_decode_wb #(
    parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] retired
);

    localparam int unsigned NREGS = 15;
    localparam logic [3:0]  RNONE = 4'hF;
    localparam logic [3:0]  RRSP  = 4'h4;

    logic [63:0] r_regs [NREGS];
    logic [63:0] r_retired;
    logic [63:0] w_rd_a;
    logic [63:0] w_rd_b;

    // Register ID decode from the instruction code
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            4'h3: dstE = rB;
            4'h4: begin
                srcA = rA;
                srcB = rB;
            end
            4'h5: begin
                srcB = rB;
                dstM = rA;
            end
            4'h6: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'h8: begin
                srcB = RRSP;
                dstE = RRSP;
            end
            4'h9: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
            end
            4'hA: begin
                srcA = rA;
                srcB = RRSP;
                dstE = RRSP;
            end
            4'hB: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Stored-value read ports; ID F matches no entry and reads 0
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i)) w_rd_a = r_regs[i];
            if (srcB == 4'(i)) w_rd_b = r_regs[i];
        end
    end

`ifdef REGFILE_DECODE_WB_BYPASS_EN
    // Forward write-back data, valM taking priority to match the write order
    always_comb begin
        valA = w_rd_a;
        valB = w_rd_b;
        if (wb_en && srcA != RNONE) begin
            if (srcA == dstM)      valA = valM;
            else if (srcA == dstE) valA = valE;
        end
        if (wb_en && srcB != RNONE) begin
            if (srcB == dstM)      valB = valM;
            else if (srcB == dstE) valB = valE;
        end
    end
`else
    always_comb begin
        valA = w_rd_a;
        valB = w_rd_b;
    end
`endif

    // Write-back: valM assigned last so it wins when both ports target one register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'h0;
            end
            r_retired <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dstE == 4'(i)) r_regs[i] <= valE;
                if (dstM == 4'(i)) r_regs[i] <= valM;
            end
            r_retired <= r_retired + 64'd1;
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_regfile_decode_wb.sv
// Directed self-checking bench for regfile_decode_wb (default build; bypass expectations under REGFILE_DECODE_WB_BYPASS_EN).
module tb_regfile_decode_wb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] retired;

    int checks;
    int failures;

    regfile_decode_wb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .srcA    (srcA),
        .srcB    (srcB),
        .dstE    (dstE),
        .dstM    (dstM),
        .valA    (valA),
        .valB    (valB),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read a register through icode 6 (srcA=rA) with write-back disabled
    task automatic rd(input logic [3:0] id, output logic [63:0] v);
        wb_en = 1'b0;
        icode = 4'h6;
        rA    = id;
        rB    = 4'hF;
        #1;
        v = valA;
    endtask

    logic [63:0] v;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        icode = 4'h0;
        rA    = 4'hF;
        rB    = 4'hF;
        cnd   = 1'b0;
        valE  = '0;
        valM  = '0;
        wb_en = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;

        chk("reset_retired", retired, 64'h0);
        icode = 4'h9; #1;
        chk("reset_rsp", valA, 64'h100);
        rd(4'h2, v);
        chk("reset_reg2", v, 64'h0);

        // nop decodes everything to none
        icode = 4'h0; rA = 4'h2; rB = 4'h3; #1;
        chk("nop_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'hFFFF);
        chk("nop_valA", valA, 64'h0);

        // irmovq to %rdx
        icode = 4'h3; rA = 4'hF; rB = 4'h2; valE = 64'h1234; wb_en = 1'b1; #1;
        chk("irmov_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'hFF2F);
        tick();
        chk("irmov_retired", retired, 64'd1);
        wb_en = 1'b0; icode = 4'h6; rA = 4'h2; rB = 4'h2; #1;
        chk("opq_valA", valA, 64'h1234);
        chk("opq_valB", valB, 64'h1234);

        // Same-edge write: old value visible until the edge
        valE = 64'h9999; wb_en = 1'b1; #1;
`ifdef REGFILE_DECODE_WB_BYPASS_EN
        chk("preedge_valA", valA, 64'h9999);
`else
        chk("preedge_valA", valA, 64'h1234);
`endif
        tick();
        wb_en = 1'b0; #1;
        chk("postedge_valA", valA, 64'h9999);
        chk("postedge_retired", retired, 64'd2);

        // cmov not taken, then taken
        icode = 4'h2; rA = 4'h1; rB = 4'h3; cnd = 1'b0; valE = 64'h5; wb_en = 1'b1; #1;
        chk("cmov_nt_dstE", {60'h0, dstE}, 64'hF);
        chk("cmov_nt_srcA", {60'h0, srcA}, 64'h1);
        tick();
        chk("cmov_nt_retired", retired, 64'd3);
        rd(4'h3, v);
        chk("cmov_nt_reg3", v, 64'h0);
        icode = 4'h2; rA = 4'h1; rB = 4'h3; cnd = 1'b1; valE = 64'h7; wb_en = 1'b1; #1;
        chk("cmov_t_dstE", {60'h0, dstE}, 64'h3);
        tick();
        rd(4'h3, v);
        chk("cmov_t_reg3", v, 64'h7);
        cnd = 1'b0;

        // popq %rsp: valM wins over valE
        icode = 4'hB; rA = 4'h4; valE = 64'h108; valM = 64'hABCD; wb_en = 1'b1; #1;
        chk("popq_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'h4444);
        tick();
        chk("popq_retired", retired, 64'd5);
        rd(4'h4, v);
        chk("popq_rsp", v, 64'hABCD);

        // wb_en=0 blocks the write and the count
        icode = 4'h3; rB = 4'h5; valE = 64'hFF; wb_en = 1'b0;
        tick();
        chk("wboff_retired", retired, 64'd5);
        rd(4'h5, v);
        chk("wboff_reg5", v, 64'h0);

        // rB=F: counted but nothing written
        icode = 4'h3; rB = 4'hF; valE = 64'h77; wb_en = 1'b1;
        tick();
        chk("rnone_retired", retired, 64'd6);
        rd(4'h2, v);
        chk("rnone_reg2", v, 64'h9999);
        rd(4'h3, v);
        chk("rnone_reg3", v, 64'h7);
        rd(4'h4, v);
        chk("rnone_reg4", v, 64'hABCD);
        rd(4'hF, v);
        chk("rnone_read", v, 64'h0);

        // Illegal icodes C..F
        for (int k = 12; k < 16; k++) begin
            icode = 4'(k); rA = 4'h2; rB = 4'h3; wb_en = 1'b0; #1;
            chk("illegal_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'hFFFF);
            chk("illegal_vals", valA | valB, 64'h0);
        end

        // mrmovq and pushq decode
        icode = 4'h5; rA = 4'h6; rB = 4'h2; #1;
        chk("mrmov_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'hF2F6);
        icode = 4'hA; rA = 4'h3; rB = 4'hF; #1;
        chk("push_ids", {48'h0, srcA, srcB, dstE, dstM}, 64'h344F);
        chk("push_valA", valA, 64'h7);
        chk("push_valB", valB, 64'hABCD);

        // Bypass case: reg1 holds 0x11, then write 0x55 via opq
        icode = 4'h3; rB = 4'h1; valE = 64'h11; wb_en = 1'b1;
        tick();
        icode = 4'h6; rA = 4'h1; rB = 4'h1; valE = 64'h55; wb_en = 1'b1; #1;
`ifdef REGFILE_DECODE_WB_BYPASS_EN
        chk("bypass_valA", valA, 64'h55);
`else
        chk("bypass_valA", valA, 64'h11);
`endif
        tick();
        chk("bypass_retired", retired, 64'd8);

        // Asynchronous reset mid-cycle with write pending
        icode = 4'h3; rB = 4'h1; valE = 64'hDEAD; wb_en = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_retired", retired, 64'h0);
        icode = 4'h6; rA = 4'h1; rB = 4'h4; #1;
        chk("async_reg1", valA, 64'h0);
        chk("async_rsp", valB, 64'h100);
        icode = 4'h3; rB = 4'h1; valE = 64'hDEAD; wb_en = 1'b1;
        tick();
        chk("inreset_retired", retired, 64'h0);
        rd(4'h1, v);
        chk("inreset_reg1", v, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        icode = 4'h3; rB = 4'h1; valE = 64'h42; wb_en = 1'b1;
        tick();
        chk("resume_retired", retired, 64'd1);
        rd(4'h1, v);
        chk("resume_reg1", v, 64'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_decode_wb.md
REGFILE_DECODE_WB -- requirements
Module: regfile_decode_wb

Interface
REQ-001 Parameter RSP_INIT, default 64'h0000_0000_0000_0100, value loaded into register 4 (%rsp) at reset.
REQ-002 clk  input  1  single clock; register-file writes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 icode  input  4  instruction code from fetch.
REQ-005 rA, rB  input  4 each  register specifiers from fetch; 4'hF = none.
REQ-006 cnd  input  1  condition result from execute; qualifies cmovXX.
REQ-007 valE, valM  input  64 each  execute result and memory read data for write-back.
REQ-008 wb_en  input  1  write-back enable; high only for a valid, non-halted, error-free instruction.
REQ-009 srcA, srcB, dstE, dstM  output  4 each  decoded register IDs.
REQ-010 valA, valB  output  64 each  register read data for srcA/srcB.
REQ-011 retired  output  64  count of instructions written back.

Function
REQ-012 The block SHALL hold 15 64-bit registers, IDs 0..14; ID 15 (RNONE) is never written and always reads 0.
REQ-013 srcA SHALL be rA for icode 2, 4, 6, A; 4 for icode 9, B; F otherwise.
REQ-014 srcB SHALL be rB for icode 4, 5, 6; 4 for icode 8, 9, A, B; F otherwise.
REQ-015 dstE SHALL be rB for icode 2 with cnd=1, and for icode 3 and 6; F for icode 2 with cnd=0; 4 for icode 8, 9, A, B; F otherwise.
REQ-016 dstM SHALL be rA for icode 5 and B; F otherwise.
REQ-017 srcA/srcB/dstE/dstM and valA/valB SHALL be combinational from current inputs and register state (zero-cycle latency).
REQ-018 On a rising clk edge with wb_en=1, the block SHALL write valE to dstE and valM to dstM, skipping any port whose ID is F.
REQ-019 If dstE==dstM (not F), the valM write SHALL win (popq %rsp semantics).
REQ-020 With wb_en=0, no register SHALL change, regardless of dstE/dstM.
REQ-021 retired SHALL increment by 1 on each rising edge with wb_en=1 and wrap from 2^64-1 to 0.
REQ-022 icode values C..F SHALL decode all four IDs to F; valA=valB=0.
REQ-023 Without bypass, a read of a register written on the same edge SHALL return the pre-edge value until that edge.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, clear registers 0-3 and 5-14 to 0, load register 4 with RSP_INIT, and clear retired to 0.
REQ-025 While rst_n=0, writes SHALL be suppressed even if wb_en=1; a write in progress at assertion SHALL be lost.
REQ-026 Writes SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro REGFILE_DECODE_WB_BYPASS_EN defined, valA/valB SHALL forward valM (priority) or valE when wb_en=1 and srcA/srcB matches dstM/dstE (not F), giving same-cycle write-then-read data.
REQ-028 With REGFILE_DECODE_WB_BYPASS_EN undefined, valA/valB SHALL come only from stored register contents.

Verification
REQ-029 Reset: rst_n=0 mid-cycle -> all regs 0, reg4=0x100, retired=0 without waiting for clk.
REQ-030 irmovq: icode=3, rB=2, valE=0x1234, wb_en=1, one edge -> reg2=0x1234, retired=1; then icode=6, rA=2, rB=2 -> valA=valB=0x1234.
REQ-031 cmov not-taken: icode=2, rA=1, rB=3, cnd=0, wb_en=1 -> dstE=F, reg3 unchanged; cnd=1, valE=7 -> reg3=7.
REQ-032 popq %rsp: icode=B, rA=4, valE=0x108, valM=0xABCD, wb_en=1 -> reg4=0xABCD.
REQ-033 wb_en=0 with icode=3, rB=5, valE=0xFF -> reg5 stays 0, retired unchanged; rB=F with wb_en=1 -> no register changes.
REQ-034 Bypass: REGFILE_DECODE_WB_BYPASS_EN defined, icode=6, rA=rB=1, dstE=1, valE=0x55, wb_en=1 -> valA=0x55 before the edge; undefined -> old reg1 value.
